video_fetch_seq: RTL
====================

# video_fetch_seq

Sequences DRAM video fetches for `video_render`. It issues word requests to the DRAM arbiter, assembles returned 16-bit words into a 64-bit shadow buffer one 16-pixel group ahead of display, and at each group boundary transfers the buffer to `pic_bits` while pulsing `fetch_sync`. It owns the prefetch/run/idle sequencing of each visible line and flags groups whose data did not arrive in time.

## Interface
- `GROUPS`, 16, number of 16-pixel groups displayed per line (1..64).
- `clk`  in  1  28 MHz system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cend`  in  1  pixel strobe (7 MHz), one `clk` wide.
- `line_start`  in  1  start of line's fetch window; only honoured when coincident with `cend`.
- `mode_zx`  in  1  1: 2 words per group; 0: 4 words per group. Sampled at `line_start`.
- `video_req`  out  1  word request to arbiter.
- `video_strobe`  in  1  one-`clk` pulse: `video_data` valid, one word delivered.
- `video_data`  in  16  returned DRAM word.
- `pic_bits`  out  64  group data to `video_render`.
- `fetch_sync`  out  1  group boundary; asserted only in a `cend` cycle.
- `active`  out  1  high while a group is being displayed.
- `underrun`  out  1  one-`clk` pulse: group transferred incomplete.

## Operation
- States: IDLE, PREFETCH, RUN. 4-bit `phase` counts `cend` within a group; group counter counts displayed groups; 2-bit word index `widx`; word target N = 2 (zx) or 4.
- IDLE: `video_req`=0. `line_start & cend` -> PREFETCH, `phase`=0, `widx`=0, shadow cleared, latch N.
- Fetch window: begins at the clk after a PREFETCH entry or after a `fetch_sync` that has a following group. `video_req`=1 while `widx` < N and window open.
- Each `video_strobe` with `video_req`=1: shadow[16*widx+15:16*widx] <= `video_data`, `widx`++. Strobes with `video_req`=0 (including after N words) are ignored.
- Word order: word0 -> bits[15:0] (pixel bytes 0,1), word1 -> [31:16] (attr bytes 0,1), word2 -> [47:32], word3 -> [63:48]. In zx mode bits[63:32] stay 0.
- Group boundary = `cend` with `phase`=15 in PREFETCH or RUN. At it: `fetch_sync`=1 (combinational with that `cend`, except at end of last group), `pic_bits` <= shadow merged with any same-cycle strobe, `underrun` pulses if merged count < N, shadow cleared, `widx`=0.
- PREFETCH boundary -> RUN group 0. RUN boundary of group g < GROUPS-1 -> group g+1. RUN group GROUPS-1 opens no fetch window (`video_req`=0); its closing boundary -> IDLE with no `fetch_sync`, no transfer, no `underrun`.
- `line_start & cend` in PREFETCH or RUN: abort, restart PREFETCH as from IDLE; `active`->0; `pic_bits` held; no `fetch_sync`/`underrun` that cycle.
- Missing words in an underrun group are 0 in `pic_bits`.

## Timing
- Reset: `video_req`=0, `pic_bits`=0, `fetch_sync`=0, `active`=0, `underrun`=0, state IDLE, all counters 0. Reset mid-line discards everything.
- `line_start` at cend C0: `video_req` high from C0+1 clk; first `fetch_sync` at cend C16; `pic_bits` valid from the clk after C16.
- `fetch_sync` at cends C16+16k, k = 0..GROUPS-1 (GROUPS pulses per line).
- `active` rises on the edge of C16, falls on the edge of C(16+16*GROUPS).
- Fetch budget per group: 16 cends (64 clk) minus one clk.
- `video_req` drops the clk after the N-th strobe; arbiter must not strobe more than once per clk.

## Test plan
- zx line, GROUPS=16, arbiter strobes 3 clk after req: 16 `fetch_sync` at C16..C256 step 16, 32 words consumed, `pic_bits`={32'h0, attr, pix} per group, no `underrun`.
- mode_zx=0, words 16'hA000+i: each group `pic_bits` = {A003,A002,A001,A000} pattern, 64 strobes total, `video_req` low in last group.
- Withhold 2nd word of group 5: `underrun` pulse at that group's transfer cend, `pic_bits`[31:16]=0, subsequent groups normal.
- Last word strobed in the boundary cend cycle: word appears in `pic_bits`, no `underrun`; extra strobe with req low ignored.
- `line_start` at group 7 of RUN: `active` drops, no further `fetch_sync` until 16 cends later, then group 0 restarts with fresh data.
- Assert `rst_n`=0 mid-fetch: all outputs 0 immediately; `line_start` after release yields normal line.

Source files
------------

// File: rtl/video_fetch_if.sv
// Signal bundle shared by the fetch sequencer, the DRAM arbiter and video_render.
// The master modport is the sequencer side; the slave modport is its environment.
interface video_fetch_if;
  logic        cend;
  logic        line_start;
  logic        mode_zx;
  logic        video_req;
  logic        video_strobe;
  logic [15:0] video_data;
  logic [63:0] pic_bits;
  logic        fetch_sync;
  logic        active;
  logic        underrun;

  modport master (
    input  cend, line_start, mode_zx, video_strobe, video_data,
    output video_req, pic_bits, fetch_sync, active, underrun
  );

  modport slave (
    output cend, line_start, mode_zx, video_strobe, video_data,
    input  video_req, pic_bits, fetch_sync, active, underrun
  );
endinterface

// File: rtl/video_fetch_seq.sv
// Per-line DRAM fetch sequencer: gathers 2 or 4 words into a shadow buffer one group
// ahead of display and hands each group to video_render at the 16-cend group boundary.
module video_fetch_seq #(
  parameter int GROUPS = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  video_fetch_if.master bus
);
  localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [GW-1:0] LAST_GRP = GW'(GROUPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [3:0]    phase_q, phase_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [2:0]    wcnt_q, wcnt_d;
  logic          zx_q, zx_d;
  logic [63:0]   shadow_q, shadow_d;
  logic [63:0]   pic_q, pic_d;
  logic          active_q, active_d;

  logic [2:0]    target;
  logic          last_grp;
  logic          window;
  logic          req;
  logic          take;
  logic          restart;
  logic          boundary;
  logic [2:0]    merged_cnt;
  logic [63:0]   merged;
  logic          fetch_sync;
  logic          underrun;

  assign target     = zx_q ? 3'd2 : 3'd4;
  assign last_grp   = (state_q == S_RUN) && (grp_q == LAST_GRP);
  // The final displayed group has nothing after it, so it never opens a window.
  assign window     = (state_q == S_PREFETCH) || ((state_q == S_RUN) && !last_grp);
  assign req        = window && (wcnt_q < target);
  assign take       = req && bus.video_strobe;
  assign restart    = bus.cend && bus.line_start;
  assign boundary   = bus.cend && (phase_q == 4'd15) && (state_q != S_IDLE);
  assign merged_cnt = wcnt_q + {2'b00, take};

  // Shadow as it would look with a same-cycle strobe folded in.
  always_comb begin
    merged = shadow_q;
    if (take) begin
      case (wcnt_q[1:0])
        2'd0:    merged[15:0]  = bus.video_data;
        2'd1:    merged[31:16] = bus.video_data;
        2'd2:    merged[47:32] = bus.video_data;
        default: merged[63:48] = bus.video_data;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    grp_d      = grp_q;
    wcnt_d     = wcnt_q;
    zx_d       = zx_q;
    shadow_d   = shadow_q;
    pic_d      = pic_q;
    active_d   = active_q;
    fetch_sync = 1'b0;
    underrun   = 1'b0;

    if (restart) begin
      state_d  = S_PREFETCH;
      phase_d  = '0;
      grp_d    = '0;
      wcnt_d   = '0;
      zx_d     = bus.mode_zx;
      shadow_d = '0;
      active_d = 1'b0;
    end else if (state_q != S_IDLE) begin
      if (bus.cend) phase_d = phase_q + 4'd1;
      if (take) begin
        shadow_d = merged;
        wcnt_d   = merged_cnt;
      end
      if (boundary) begin
        shadow_d = '0;
        wcnt_d   = '0;
        if (last_grp) begin
          state_d  = S_IDLE;
          grp_d    = '0;
          active_d = 1'b0;
        end else begin
          fetch_sync = 1'b1;
          underrun   = (merged_cnt < target);
          pic_d      = merged;
          active_d   = 1'b1;
          if (state_q == S_PREFETCH) begin
            state_d = S_RUN;
            grp_d   = '0;
          end else begin
            grp_d = grp_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      grp_q    <= '0;
      wcnt_q   <= '0;
      zx_q     <= 1'b0;
      shadow_q <= '0;
      pic_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      grp_q    <= grp_d;
      wcnt_q   <= wcnt_d;
      zx_q     <= zx_d;
      shadow_q <= shadow_d;
      pic_q    <= pic_d;
      active_q <= active_d;
    end
  end

  assign bus.video_req  = req;
  assign bus.pic_bits   = pic_q;
  assign bus.fetch_sync = fetch_sync;
  assign bus.active     = active_q;
  assign bus.underrun   = underrun;
endmodule
